// File: rtl/bcd_alu_pkg.sv
// Shared opcodes, sequencer states and BCD digit helper for the
// BCD ALU sequencer slice.
package bcd_alu_pkg;

    localparam logic [3:0] OP_ADD = 4'hA;
    localparam logic [3:0] OP_SUB = 4'hB;
    localparam logic [3:0] OP_MUL = 4'hC;
    localparam logic [3:0] OP_DIV = 4'hD;

    typedef enum logic [2:0] {
        IDLE,
        ADDSUB,
        MUL_SHIFT,
        MUL_ADD,
        DIV_SHIFT,
        DIV_SUB,
        FINISH
    } state_t;

    function automatic logic digit_ok(input logic [3:0] d);
        return d <= 4'd9;
    endfunction

endpackage

// File: rtl/bcd_alu_sequencer_if.sv
// Request/result bundle between the calculator FSM and the BCD ALU.
// Define BCD_ALU_SEQ_REM_EN to carry the divide remainder on rem.
interface bcd_alu_sequencer_if #(
    parameter int NDIG = 4
);
    logic              start;
    logic [3:0]        op;
    logic [4*NDIG-1:0] num1;
    logic [4*NDIG-1:0] num2;
    logic [4*NDIG-1:0] res;
    logic              busy;
    logic              done;
    logic              neg;
    logic              ovf;
    logic              err;
`ifdef BCD_ALU_SEQ_REM_EN
    logic [4*NDIG-1:0] rem;
`endif

    modport master (
        output start, op, num1, num2,
        input  res, busy, done, neg, ovf, err
`ifdef BCD_ALU_SEQ_REM_EN
        , input rem
`endif
    );

    modport slave (
        input  start, op, num1, num2,
        output res, busy, done, neg, ovf, err
`ifdef BCD_ALU_SEQ_REM_EN
        , output rem
`endif
    );

endinterface

// File: rtl/bcd_addsub_n.sv
// Combinational ripple BCD adder/subtractor over NDIG+1 digits.
// Subtract is a + 9's complement(b) + 1; cout=1 then means a >= b.
module bcd_addsub_n #(
    parameter int NDIG = 4
) (
    input  logic [4*(NDIG+1)-1:0] a,
    input  logic [4*(NDIG+1)-1:0] b,
    input  logic                  sub,
    output logic [4*(NDIG+1)-1:0] y,
    output logic                  cout
);

    logic [3:0] bd;
    logic [4:0] s;
    logic       c;

    // Digit-serial ripple with decimal correction per digit.
    always_comb begin
        y  = '0;
        bd = '0;
        s  = '0;
        c  = sub;
        for (int i = 0; i <= NDIG; i++) begin
            bd = sub ? (4'd9 - b[4*i+:4]) : b[4*i+:4];
            s  = {1'b0, a[4*i+:4]} + {1'b0, bd} + {4'd0, c};
            if (s > 5'd9) begin
                y[4*i+:4] = 4'(s - 5'd10);
                c         = 1'b1;
            end else begin
                y[4*i+:4] = s[3:0];
                c         = 1'b0;
            end
        end
        cout = c;
    end

endmodule

// File: rtl/bcd_alu_sequencer.sv
// Multi-cycle BCD add/sub/mul/div sequencer on one shared adder.
// Define BCD_ALU_SEQ_REM_EN to expose the divide remainder on rem.
module bcd_alu_sequencer
    import bcd_alu_pkg::*;
#(
    parameter int NDIG = 4
) (
    input logic               clk,
    input logic               reset,
    bcd_alu_sequencer_if.slave bus
);

    localparam int W  = 4 * NDIG;
    localparam int WX = 4 * (NDIG + 1);
    localparam int DW = $clog2(NDIG + 1);

    state_t          state, state_nxt;
    logic [3:0]      op_q;
    logic [W-1:0]    a_q, b_q, res_q;
    logic [WX-1:0]   rmd_q;
    logic [3:0]      cnt_q;
    logic [DW-1:0]   dcnt_q;
    logic            bad_q, neg_q, ovf_q, err_q;

    logic [WX-1:0]   add_a, add_b, add_y;
    logic            add_sub, add_co;
    logic            in_ok, swap;

    bcd_addsub_n #(.NDIG(NDIG)) u_addsub (
        .a    (add_a),
        .b    (add_b),
        .sub  (add_sub),
        .y    (add_y),
        .cout (add_co)
    );

    // Request check: known opcode, all digits 0-9, nonzero divisor.
    always_comb begin
        in_ok = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (!digit_ok(bus.num1[4*i+:4]) ||
                !digit_ok(bus.num2[4*i+:4]))
                in_ok = 1'b0;
        end
        if (!(bus.op inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV}))
            in_ok = 1'b0;
        if (bus.op == OP_DIV && bus.num2 == '0)
            in_ok = 1'b0;
    end

    // Packed BCD orders like binary, so A<B picks the magnitude order.
    assign swap = (op_q == OP_SUB) && (a_q < b_q);

    // Steer the shared adder for the active sequence step.
    always_comb begin
        add_a   = {4'd0, a_q};
        add_b   = {4'd0, b_q};
        add_sub = 1'b0;
        unique case (state)
            ADDSUB: begin
                add_sub = (op_q == OP_SUB);
                if (swap) begin
                    add_a = {4'd0, b_q};
                    add_b = {4'd0, a_q};
                end
            end
            MUL_ADD: begin
                add_a = {4'd0, res_q};
                add_b = {4'd0, a_q};
            end
            DIV_SUB: begin
                add_a   = rmd_q;
                add_b   = {4'd0, b_q};
                add_sub = 1'b1;
            end
            default: ;
        endcase
    end

    // Next-state selection.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    if (!in_ok)                state_nxt = ADDSUB;
                    else if (bus.op == OP_MUL) state_nxt = MUL_SHIFT;
                    else if (bus.op == OP_DIV) state_nxt = DIV_SHIFT;
                    else                       state_nxt = ADDSUB;
                end
            end
            ADDSUB: state_nxt = FINISH;
            MUL_SHIFT: begin
                if (b_q[W-1-:4] != 4'd0)    state_nxt = MUL_ADD;
                else if (dcnt_q == DW'(1)) state_nxt = FINISH;
                else                       state_nxt = MUL_SHIFT;
            end
            MUL_ADD: begin
                if (cnt_q == 4'd1)
                    state_nxt = (dcnt_q == '0) ? FINISH : MUL_SHIFT;
            end
            DIV_SHIFT: state_nxt = DIV_SUB;
            DIV_SUB: begin
                if (!add_co)
                    state_nxt = (dcnt_q == '0) ? FINISH : DIV_SHIFT;
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Operand, accumulator, remainder and flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            rmd_q  <= '0;
            cnt_q  <= '0;
            dcnt_q <= '0;
            bad_q  <= 1'b0;
            neg_q  <= 1'b0;
            ovf_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q   <= bus.op;
                        a_q    <= bus.num1;
                        b_q    <= bus.num2;
                        res_q  <= '0;
                        rmd_q  <= '0;
                        cnt_q  <= '0;
                        dcnt_q <= DW'(NDIG);
                        bad_q  <= !in_ok;
                        neg_q  <= 1'b0;
                        ovf_q  <= 1'b0;
                        err_q  <= 1'b0;
                    end
                end
                ADDSUB: begin
                    if (bad_q) begin
                        err_q <= 1'b1;
                    end else begin
                        res_q <= add_y[W-1:0];
                        ovf_q <= (add_y[WX-1-:4] != 4'd0);
                        neg_q <= swap;
                    end
                end
                MUL_SHIFT: begin
                    res_q  <= {res_q[W-5:0], 4'd0};
                    if (res_q[W-1-:4] != 4'd0) ovf_q <= 1'b1;
                    cnt_q  <= b_q[W-1-:4];
                    b_q    <= {b_q[W-5:0], 4'd0};
                    dcnt_q <= dcnt_q - DW'(1);
                end
                MUL_ADD: begin
                    res_q <= add_y[W-1:0];
                    if (add_y[WX-1-:4] != 4'd0) ovf_q <= 1'b1;
                    cnt_q <= cnt_q - 4'd1;
                end
                DIV_SHIFT: begin
                    rmd_q  <= {rmd_q[W-1:0], a_q[W-1-:4]};
                    a_q    <= {a_q[W-5:0], 4'd0};
                    cnt_q  <= '0;
                    dcnt_q <= dcnt_q - DW'(1);
                end
                DIV_SUB: begin
                    if (add_co) begin
                        rmd_q <= add_y;
                        cnt_q <= cnt_q + 4'd1;
                    end else begin
                        res_q <= {res_q[W-5:0], cnt_q};
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.res  = res_q;
    assign bus.busy = (state != IDLE);
    assign bus.done = (state == FINISH);
    assign bus.neg  = neg_q;
    assign bus.ovf  = ovf_q;
    assign bus.err  = err_q;
`ifdef BCD_ALU_SEQ_REM_EN
    assign bus.rem  = rmd_q[W-1:0];
`endif

endmodule

// File: tb/tb_bcd_alu_sequencer.sv
// Self-checking bench for bcd_alu_sequencer: vector table, random
// model-checked ops, busy-start and mid-operation reset sequences.
module tb_bcd_alu_sequencer;

    localparam int NDIG = 4;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [15:0] rem;
        logic [2:0]  flg;
        int          lat;
        bit          exact;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t sb[$];

    bcd_alu_sequencer_if #(.NDIG(NDIG)) bus ();

    bcd_alu_sequencer #(.NDIG(NDIG)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int b2i(input logic [15:0] x);
        int r = 0;
        for (int i = 3; i >= 0; i--) r = r * 10 + int'(x[4*i+:4]);
        return r;
    endfunction

    function automatic logic [15:0] i2b(input int v);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) begin
            r[4*i+:4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic vec_t model(input logic [3:0] op,
                                   input logic [15:0] a,
                                   input logic [15:0] b);
        vec_t v;
        int x = b2i(a);
        int y = b2i(b);
        int r;
        v.op = op; v.a = a; v.b = b;
        v.res = '0; v.rem = '0; v.flg = '0;
        v.lat = 2; v.exact = 1'b1;
        case (op)
            4'hA: begin
                r = x + y;
                v.res = i2b(r % 10000);
                v.flg[1] = (r > 9999);
            end
            4'hB: begin
                if (x < y) begin
                    v.res = i2b(y - x);
                    v.flg[2] = 1'b1;
                end else begin
                    v.res = i2b(x - y);
                end
            end
            4'hC: begin
                r = x * y;
                v.res = i2b(r % 10000);
                v.flg[1] = (r > 9999);
                v.lat = 5;
                for (int i = 0; i < 4; i++) v.lat += int'(b[4*i+:4]);
            end
            4'hD: begin
                if (y == 0) begin
                    v.flg[0] = 1'b1;
                end else begin
                    v.res = i2b(x / y);
                    v.rem = i2b(x % y);
                    v.lat = 45;
                    v.exact = 1'b0;
                end
            end
            default: v.flg[0] = 1'b1;
        endcase
        return v;
    endfunction

    task automatic drive(input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.num1  = a;
        bus.num2  = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int lat);
        lat = 1;
        while (bus.done !== 1'b1 && lat < budget) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        vec_t e;
        int   lat;
        sb.push_back(v);
        drive(v.op, v.a, v.b);
        check({tag, ".busy"}, 32'(bus.busy), 32'd1);
        wait_done(60, lat);
        check({tag, ".done"}, 32'(bus.done), 32'd1);
        e = sb.pop_front();
        check({tag, ".res"}, 32'(bus.res), 32'(e.res));
        check({tag, ".flags"}, 32'({bus.neg, bus.ovf, bus.err}),
              32'(e.flg));
`ifdef BCD_ALU_SEQ_REM_EN
        check({tag, ".rem"}, 32'(bus.rem), 32'(e.rem));
`endif
        if (e.exact) check({tag, ".lat"}, lat, e.lat);
        else check({tag, ".lat_max"}, 32'(lat <= e.lat), 32'd1);
        @(negedge clk);
        check({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
        check({tag, ".idle"}, 32'(bus.busy), 32'd0);
        @(negedge clk);
        check({tag, ".hold"}, 32'(bus.res), 32'(e.res));
    endtask

    vec_t tbl[13];
    vec_t v;
    int   lat;
    int   nd;

    initial begin
        tbl[0]  = '{4'hA, 16'h9999, 16'h0001, 16'h0000, 16'h0000, 3'b010, 2, 1'b1};
        tbl[1]  = '{4'hA, 16'h1234, 16'h4321, 16'h5555, 16'h0000, 3'b000, 2, 1'b1};
        tbl[2]  = '{4'hB, 16'h0003, 16'h0010, 16'h0007, 16'h0000, 3'b100, 2, 1'b1};
        tbl[3]  = '{4'hB, 16'h0010, 16'h0003, 16'h0007, 16'h0000, 3'b000, 2, 1'b1};
        tbl[4]  = '{4'hC, 16'h0012, 16'h0034, 16'h0408, 16'h0000, 3'b000, 41, 1'b0};
        tbl[5]  = '{4'hC, 16'h9999, 16'h0002, 16'h9998, 16'h0000, 3'b010, 41, 1'b0};
        tbl[6]  = '{4'hD, 16'h1000, 16'h0007, 16'h0142, 16'h0006, 3'b000, 45, 1'b0};
        tbl[7]  = '{4'hD, 16'h0005, 16'h0000, 16'h0000, 16'h0000, 3'b001, 2, 1'b1};
        tbl[8]  = '{4'h3, 16'h0001, 16'h0001, 16'h0000, 16'h0000, 3'b001, 2, 1'b1};
        tbl[9]  = '{4'hA, 16'h12A4, 16'h0001, 16'h0000, 16'h0000, 3'b001, 2, 1'b1};
        tbl[10] = '{4'hB, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'b000, 2, 1'b1};
        tbl[11] = '{4'hD, 16'h9999, 16'h0003, 16'h3333, 16'h0000, 3'b000, 45, 1'b0};
        tbl[12] = '{4'hC, 16'h9999, 16'h9999, 16'h0001, 16'h0000, 3'b010, 41, 1'b1};

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = '0;
        bus.num1  = '0;
        bus.num2  = '0;
        repeat (2) @(negedge clk);
        check("rst.res", 32'(bus.res), 32'd0);
        check("rst.busy", 32'(bus.busy), 32'd0);
        check("rst.done", 32'(bus.done), 32'd0);
        check("rst.flags", 32'({bus.neg, bus.ovf, bus.err}), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

        for (int i = 0; i < 8; i++) begin
            logic [3:0]  op;
            logic [15:0] a, b;
            op = 4'hA + 4'($urandom_range(0, 3));
            a  = i2b(int'($urandom_range(0, 9999)));
            b  = i2b(int'($urandom_range(1, 9999)));
            if (op == 4'hC) b = i2b(int'($urandom_range(0, 99)));
            run_vec(model(op, a, b), $sformatf("rnd%0d", i));
        end

        v = model(4'hC, 16'h0012, 16'h0034);
        sb.push_back(v);
        drive(v.op, v.a, v.b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 4'hA;
        bus.num1  = 16'h1111;
        bus.num2  = 16'h1111;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(60, lat);
        check("busy_start.done", 32'(bus.done), 32'd1);
        v = sb.pop_front();
        check("busy_start.res", 32'(bus.res), 32'(v.res));
        check("busy_start.flags", 32'({bus.neg, bus.ovf, bus.err}), 32'(v.flg));
        @(negedge clk);
        nd = 0;
        repeat (20) begin
            if (bus.done === 1'b1) nd++;
            @(negedge clk);
        end
        check("busy_start.single_done", nd, 0);

        drive(4'hC, 16'h9999, 16'h9999);
        repeat (4) @(negedge clk);
        check("mid_rst.busy_before", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst.res", 32'(bus.res), 32'd0);
        check("mid_rst.busy", 32'(bus.busy), 32'd0);
        check("mid_rst.done", 32'(bus.done), 32'd0);
        check("mid_rst.flags", 32'({bus.neg, bus.ovf, bus.err}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        nd = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.done === 1'b1) nd++;
        end
        check("mid_rst.no_done", nd, 0);
        run_vec(model(4'hC, 16'h0025, 16'h0004), "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_alu_sequencer.md
Name: bcd_alu_sequencer

Overview:
Multi-cycle BCD arithmetic controller placed between the main calculator FSM and the result/display path. It latches two packed-BCD operands and an opcode on a start pulse and sequences one shared BCD add/subtract datapath. Add/sub take one pass; multiply uses shift-and-add, divide uses restoring long division. It returns a registered result with status flags and a done pulse.

Parameters:
NDIG, 4, number of BCD digits per operand/result (operand width = 4*NDIG)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  1-cycle request; sampled only in IDLE
op  in  4  opcode: 4'hA add, 4'hB sub, 4'hC mul, 4'hD div
num1  in  4*NDIG  packed BCD operand A (dividend/minuend)
num2  in  4*NDIG  packed BCD operand B (divisor/subtrahend)
res  out  4*NDIG  packed BCD result; held until next accepted start
busy  out  1  high from cycle after accepted start through FINISH inclusive
done  out  1  high exactly during the FINISH cycle
neg  out  1  sub result negative (res holds magnitude)
ovf  out  1  result exceeded NDIG digits (res holds low NDIG digits)
err  out  1  div by zero, invalid op, or non-BCD digit (>9); res=0

Behaviour:
- Reset (async): state=IDLE; res, busy, done, neg, ovf, err, internal registers = 0. Reset mid-operation discards the computation; no done is issued.
- IDLE + start=1 at edge k: latch op/num1/num2, clear flags, go to op state; busy=1 from cycle k+1. start while busy is ignored, not queued.
- Validation on entry: invalid op or any digit >9 -> FINISH directly with err=1, res=0.
- ADDSUB (1 cycle): add: res=A+B, ovf=carry out of top digit. sub: 10's-complement A-B; if borrow then res=B-A, neg=1. Then FINISH.
  - Add latency: done at cycle k+2.
- Multiply: acc=0; multiplier digits are processed MSD first.
  - MUL_SHIFT: acc<<=1 digit; set ovf if the dropped digit is nonzero.
  - MUL_ADD: repeat d times (d = current multiplier digit) acc+=A; set ovf on carry.
  - Digit 0 performs shift only.
  - After LSD -> FINISH.
  - Worst case NDIG*10+1 cycles.
- Divide: if B==0 -> FINISH, err=1. Else R (NDIG+1 digits)=0, Q=0; for each dividend digit MSD first:
  - DIV_SHIFT: R=R*10+digit; qd=0.
  - DIV_SUB: while R>=B: R-=B, qd++ (one subtraction per cycle; qd<=9 guaranteed).
  - Then Q=Q*10+qd.
  - After LSD: res=Q -> FINISH.
  - Worst case NDIG*11+1 cycles.
- FINISH: done=1, busy=1, res/flags valid (already registered); next cycle IDLE, busy=0. Outputs remain stable in IDLE.
- Flags are mutually exclusive except neg, which is set only for sub.

Optional Feature:
BCD_ALU_SEQ_REM_EN:
- Defined: adds output rem[4*NDIG-1:0] = final divide remainder, valid at done, 0 for other ops and on reset.
- Undefined: port and remainder output logic absent; R stays internal only.

Decomposition:
- Package bcd_alu_pkg: opcode localparams (OP_ADD..OP_DIV), state enum (IDLE, ADDSUB, MUL_SHIFT, MUL_ADD, DIV_SHIFT, DIV_SUB, FINISH), and a digit-validity function.
- Sub-module bcd_addsub_n: combinational NDIG+1-digit BCD adder/subtractor with carry/borrow out. One instance is shared by all sequences.

Test Plan:
- add 9999+0001 -> done at k+2, res=0000, ovf=1; 1234+4321 -> 5555, flags 0.
- sub 0003-0010 -> res=0007, neg=1; 0010-0003 -> 0007, neg=0.
- mul 0012*0034 -> res=0408, done within 41 cycles; 9999*0002 -> ovf=1, res=9998.
- div 1000/0007 -> res=0142 (rem=0006 with BCD_ALU_SEQ_REM_EN); 0005/0000 -> err=1, res=0000.
- invalid inputs: op=4'h3 or num1=16'h12A4 -> err=1 at k+2; start pulsed while busy -> ignored, single done.
- reset asserted mid-multiply -> all outputs 0 immediately, IDLE; next start computes correctly.
